// File: rtl/bcd_cascade_counter.sv
// rtl/bcd_cascade_counter.sv - N-digit cascaded BCD counter with programmable terminal value, wrap or hold
// Optional down-count support (dir port) is enabled by defining BCD_COUNTER_DOWN_EN.
module bcd_cascade_counter #(
    parameter int                  DIGITS = 4,
    parameter logic [4*DIGITS-1:0] TARGET = 16'h9675
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ena,
`ifdef BCD_COUNTER_DOWN_EN
    input  logic                  dir,
`endif
    input  logic                  clr,
    input  logic                  hold_at_target,
    output logic [4*DIGITS-1:0]   Qdata,
    output logic [DIGITS-1:0]     blink,
    output logic                  at_target,
    output logic                  done,
    output logic                  wrap
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0] q_inc;
    logic         inc_all_nine;

    // Each digit steps only while every lower digit sits at 9; no cross-digit adder.
    always_comb begin
        logic chain;
        chain = 1'b1;
        q_inc = Qdata;
        for (int i = 0; i < DIGITS; i++) begin
            if (chain) begin
                q_inc[4*i +: 4] = (Qdata[4*i +: 4] >= 4'd9) ? 4'd0 : Qdata[4*i +: 4] + 4'd1;
            end
            chain = chain && (Qdata[4*i +: 4] == 4'd9);
        end
        inc_all_nine = chain;
    end

`ifdef BCD_COUNTER_DOWN_EN
    logic [W-1:0] q_dec;

    always_comb begin
        logic chain;
        chain = 1'b1;
        q_dec = Qdata;
        for (int i = 0; i < DIGITS; i++) begin
            if (chain) begin
                q_dec[4*i +: 4] = (Qdata[4*i +: 4] == 4'd0) ? 4'd9
                                : (Qdata[4*i +: 4] > 4'd9) ? 4'd9
                                : Qdata[4*i +: 4] - 4'd1;
            end
            chain = chain && (Qdata[4*i +: 4] == 4'd0);
        end
    end
`endif

    always_comb begin
        blink = '0;
        for (int i = 0; i < DIGITS; i++) begin
            blink[i] = (Qdata[4*i +: 4] == TARGET[4*i +: 4]);
        end
    end

    assign at_target = (Qdata == TARGET);

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            Qdata <= '0;
            done  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (ena && !done) begin
`ifdef BCD_COUNTER_DOWN_EN
                if (dir) begin
                    if (Qdata == '0) begin
                        if (hold_at_target) begin
                            done <= 1'b1;
                        end else begin
                            Qdata <= TARGET;
                            wrap  <= 1'b1;
                        end
                    end else begin
                        Qdata <= q_dec;
                    end
                end else
`endif
                if (Qdata == TARGET) begin
                    if (hold_at_target) begin
                        done <= 1'b1;
                    end else begin
                        Qdata <= '0;
                        wrap  <= 1'b1;
                    end
                end else begin
                    // All-nines rollover is only reachable when TARGET holds a non-BCD nibble.
                    Qdata <= q_inc;
                    wrap  <= inc_all_nine;
                end
            end
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_target_check
        if (TARGET[4*g +: 4] > 4'd9) begin : g_bad_digit
            $error("bcd_cascade_counter: TARGET digit %0d is not a BCD value", g);
        end
    end

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// tb/tb_bcd_cascade_counter.sv - scoreboard bench for bcd_cascade_counter against a decimal reference model
module tb_bcd_cascade_counter;

    localparam logic [15:0] TARGET_BCD = 16'h9675;
    localparam int          TGT_DEC    = 9675;

    logic        clk = 1'b0;
    logic        reset;
    logic        ena;
    logic        clr;
    logic        hold_at_target;
`ifdef BCD_COUNTER_DOWN_EN
    logic        dir = 1'b0;
`endif
    logic [15:0] Qdata;
    logic [3:0]  blink;
    logic        at_target;
    logic        done;
    logic        wrap;

    bcd_cascade_counter #(.DIGITS(4), .TARGET(TARGET_BCD)) dut (
        .clk            (clk),
        .reset          (reset),
        .ena            (ena),
`ifdef BCD_COUNTER_DOWN_EN
        .dir            (dir),
`endif
        .clr            (clr),
        .hold_at_target (hold_at_target),
        .Qdata          (Qdata),
        .blink          (blink),
        .at_target      (at_target),
        .done           (done),
        .wrap           (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] q;
        logic        done;
        logic        wrap;
        logic        at;
        logic [3:0]  blink;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    int cnt   = 0;
    bit mdone = 1'b0;
    bit mwrap = 1'b0;
    int n_wraps = 0;
    int n_dones = 0;

    function automatic int digit_of(input int v, input int i);
        int p;
        p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        return (v / p) % 10;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'(digit_of(v, i));
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    // One clock of stimulus; the model advances by the decimal rules and queues what the DUT must show next.
    task automatic step(input bit r, input bit c, input bit e, input bit h);
        exp_t x;
        @(negedge clk);
        reset = r;
        clr = c;
        ena = e;
        hold_at_target = h;
        if (!r || c) begin
            cnt = 0;
            mdone = 1'b0;
            mwrap = 1'b0;
        end else begin
            mwrap = 1'b0;
            if (e && !mdone) begin
                if (cnt == TGT_DEC) begin
                    if (h) begin
                        mdone = 1'b1;
                        n_dones++;
                    end else begin
                        cnt = 0;
                        mwrap = 1'b1;
                        n_wraps++;
                    end
                end else begin
                    cnt = cnt + 1;
                    if (cnt == 10000) begin
                        cnt = 0;
                        mwrap = 1'b1;
                    end
                end
            end
        end
        x.q = to_bcd(cnt);
        x.done = mdone;
        x.wrap = mwrap;
        x.at = (cnt == TGT_DEC);
        for (int i = 0; i < 4; i++) x.blink[i] = (digit_of(cnt, i) == digit_of(TGT_DEC, i));
        sbq.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                x = sbq.pop_front();
                check("qdata", 32'(Qdata), 32'(x.q));
                check("done", 32'(done), 32'(x.done));
                check("wrap", 32'(wrap), 32'(x.wrap));
                check("at_target", 32'(at_target), 32'(x.at));
                check("blink", 32'(blink), 32'(x.blink));
            end
        end
    end

    initial begin : driver
        bit h;
        reset = 1'b0;
        clr = 1'b0;
        ena = 1'b0;
        hold_at_target = 1'b0;

        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        for (int k = 0; k < 10; k++) step(1, 0, 1, 0);
        for (int k = 0; k < 20; k++) step(1, 0, (k % 2) == 0, 0);
        step(1, 1, 1, 0);

        // Long runs reach TARGET; run 0 wraps, run 1 holds then toggles hold, later runs randomise hold.
        for (int run = 0; run < 4; run++) begin
            step(1, 1, 0, 0);
            for (int k = 0; k < 11500; k++) begin
                if (run == 0) h = 1'b0;
                else if (run == 1) h = mdone ? 1'(($urandom_range(1))) : 1'b1;
                else h = 1'(($urandom_range(1)));
                step(1, 0, $urandom_range(7) != 0, h);
            end
        end

        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(399) != 0, $urandom_range(299) == 0,
                 $urandom_range(1) == 1, 1'(($urandom_range(1))));
        end

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        check("wrap_seen", 32'(n_wraps > 0), 32'd1);
        check("done_seen", 32'(n_dones > 0), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_cascade_counter.md
Name: bcd_cascade_counter

Overview:
- Parametrised N-digit cascaded BCD counter with a programmable terminal value. It is the successor to the fixed four-digit counter bank.
- Digits carry into each other, so the word counts 0..TARGET in decimal.
- Per-digit match flags drive the board LEDs. Terminal handling is selectable between wrap and hold-at-target.
- Sits between the enable/prescaler logic and the seven-segment and LED drivers.

Parameters:
- DIGITS, 4, number of BCD digits; Qdata width is 4*DIGITS.
- TARGET, 16'h9675, terminal value in packed BCD, width 4*DIGITS. Every nibble must be ≤ 9.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- reset  input  1  synchronous, active-low reset. Sampled only on the rising edge of clk; 0 = reset.
- ena  input  1  count enable; one step per clk cycle while high.
- clr  input  1  synchronous clear, active-high. Same effect as reset, lower priority.
- hold_at_target  input  1  1 = stop at TARGET; 0 = wrap to 0 after TARGET.
- Qdata  output  4*DIGITS  registered packed BCD count; digit i is Qdata[4i+3:4i].
- blink  output  DIGITS  blink[i] = 1 when digit i equals digit i of TARGET. Combinational from Qdata, zero latency.
- at_target  output  1  combinational; 1 when Qdata == TARGET.
- done  output  1  registered, sticky; set when the counter stops at TARGET in hold mode.
- wrap  output  1  registered one-cycle pulse; 1 in the cycle Qdata first shows 0 after a wrap.

Behaviour:
- Priority on each rising clk edge: reset low, then clr, then ena, then hold.
- Reset (reset=0): Qdata=0, done=0, wrap=0. blink and at_target follow from Qdata=0 against TARGET.
- clr=1 (with reset=1): identical to reset.
- ena=0: Qdata and done hold; wrap=0.
- ena=1, done=1: no change; wrap=0. done is sticky until reset/clr, even if hold_at_target drops.
- ena=1, done=0, Qdata != TARGET: BCD increment.
  - Digit 0 always steps.
  - Digit i steps only when digits 0..i-1 are all 9.
  - A stepping digit goes 9 -> 0, otherwise +1.
  - If every digit is 9, Qdata becomes 0 and wrap=1 next cycle. This path is reachable only with an invalid TARGET.
- ena=1, done=0, Qdata == TARGET:
  - hold_at_target=1: Qdata holds, done<=1.
  - hold_at_target=0: Qdata<=0, wrap<=1.
- wrap is 0 in every cycle not covered above.
- No non-BCD nibble ever appears on Qdata.
- hold_at_target is sampled only on the edge where Qdata == TARGET. Changing it at any other time has no effect.
- Latency:
  - Qdata updates one cycle after the enabling edge.
  - blink and at_target are valid in the same cycle as Qdata.
  - done and wrap appear one cycle after the edge that caused them.
- Carry logic is a per-digit "all lower digits at 9" chain. There are no cross-digit adders.
- Simulation-only check: $error at time 0 if any nibble of TARGET > 9.

Optional Feature:
- Macro: BCD_COUNTER_DOWN_EN.
- Defined: adds input port dir (1 bit, placed after ena).
  - dir=0: behaviour exactly as above.
  - dir=1: BCD decrement. Digit i borrows when digits 0..i-1 are all 0, and a borrowing digit goes 0 -> 9.
  - dir=1 terminal is Qdata == 0:
    - hold_at_target=1: hold and set done.
    - hold_at_target=0: reload TARGET and pulse wrap.
  - at_target and blink still compare against TARGET.
  - dir changes take effect on the next enabled edge.
- Not defined: no dir port; up-count only.

Test Plan (DIGITS=4, TARGET=16'h9675 unless stated):
1. reset=0 for 2 cycles with ena=1 -> Qdata=0000, done=0, wrap=0, blink=0000. Release reset, ena=1 for 10 cycles -> Qdata=0010.
2. Preload by counting to 0099, then one more ena -> Qdata=0100. Repeat from 0999 -> 1000 (carry chain across three digits).
3. hold_at_target=0, count from 9674 -> next edge Qdata=9675, at_target=1, blink=1111. Next edge -> Qdata=0000 and wrap=1 for exactly one cycle.
4. hold_at_target=1, reach 9675, keep ena=1 for 5 cycles -> Qdata stays 9675, done=1 from the cycle after the hit. Drop hold_at_target -> done stays 1. clr=1 -> Qdata=0000, done=0.
5. ena toggled 1/0 every cycle for 20 cycles -> Qdata=0010. Assert clr and ena in the same cycle -> Qdata=0000. Assert reset=0 at 5000 mid-count -> Qdata=0000 on that edge.
6. BCD_COUNTER_DOWN_EN defined, dir=1, hold_at_target=0, start at 0001 -> 0000, then 9675 with wrap=1. From 1000 with dir=1 -> 0999.
